// File: rtl/response_parser_pkg.sv
// ---------------------------------------------------------------------------
// response_parser_pkg
// Shared definitions for the response line parser: FSM state encoding,
// error-cause codes reported on err_code, and the ASCII bytes that make up
// a response line of the form "> " + binary digits + "\n".
// ---------------------------------------------------------------------------
package response_parser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPACE  = 3'd1,
        DIGITS = 3'd2,
        HOLD   = 3'd3,
        SKIP   = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_BAD_PREFIX = 3'd1;
    localparam logic [2:0] ERR_BAD_DIGIT  = 3'd2;
    localparam logic [2:0] ERR_SHORT      = 3'd3;
    localparam logic [2:0] ERR_LONG       = 3'd4;

    localparam logic [7:0] ASCII_GT    = 8'h3E;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_NL    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_ONE   = 8'h31;
    localparam logic [7:0] ASCII_X     = 8'h78;
    localparam logic [7:0] ASCII_Z     = 8'h7A;

    // OR-ing this bit into an ASCII letter folds upper case onto lower case.
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

endpackage

// File: rtl/ascii_bin_classify.sv
// ---------------------------------------------------------------------------
// ascii_bin_classify
// Purely combinational byte decoder used by the response line parser.
//
// Ports:
//   data     in  8  ASCII byte to classify
//   is_zero  out 1  byte is '0'
//   is_one   out 1  byte is '1'
//   is_xz    out 1  byte is one of 'x', 'X', 'z', 'Z'
//   is_nl    out 1  byte is '\n'
// ---------------------------------------------------------------------------
module ascii_bin_classify
    import response_parser_pkg::*;
(
    input  logic [7:0] data,
    output logic       is_zero,
    output logic       is_one,
    output logic       is_xz,
    output logic       is_nl
);

    logic [7:0] folded;

    // Only 'X'/'x' and 'Z'/'z' fold onto the lower-case codes, so a single
    // compare per letter after folding covers both cases.
    assign folded  = data | ASCII_CASE_BIT;

    assign is_zero = (data == ASCII_ZERO);
    assign is_one  = (data == ASCII_ONE);
    assign is_xz   = (folded == ASCII_X) || (folded == ASCII_Z);
    assign is_nl   = (data == ASCII_NL);

endmodule

// File: rtl/response_line_parser.sv
// ---------------------------------------------------------------------------
// response_line_parser
// Turns the ASCII response stream ("> " + WIDTH binary digits + "\n" per
// line) into WIDTH-bit vectors on a valid/ready interface, and reports
// malformed lines with a one-cycle err pulse plus a held err_code.
//
// Parameters:
//   WIDTH      digits per line (1..32), first digit received becomes MSB
//
// Ports:
//   CLK        in   1      clock, rising edge
//   RESET      in   1      synchronous active-high reset
//   in_data    in   8      ASCII byte from the transport
//   in_valid   in   1      in_data valid
//   in_ready   out  1      byte accepted this cycle (low only while holding)
//   out_vec    out  WIDTH  parsed vector
//   out_valid  out  1      out_vec valid
//   out_ready  in   1      downstream accepts out_vec
//   out_known  out  WIDTH  (RESPONSE_PARSER_XZ_EN only) 1 where digit was 0/1
//   err        out  1      one-cycle pulse on a malformed line
//   err_code   out  3      cause of the most recent error
//
// Build option: define RESPONSE_PARSER_XZ_EN to accept x/X/z/Z digits and
// expose out_known; otherwise those characters are reported as bad digits.
// ---------------------------------------------------------------------------
module response_line_parser
    import response_parser_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef RESPONSE_PARSER_XZ_EN
    output logic [WIDTH-1:0] out_known,
`endif
    output logic             err,
    output logic [2:0]       err_code
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] count;
    logic             byte_fire;
    logic             is_zero;
    logic             is_one;
    logic             is_xz;
    logic             is_nl;
    logic             is_digit;

`ifdef RESPONSE_PARSER_XZ_EN
    logic [WIDTH-1:0] known_reg;
`endif

    ascii_bin_classify u_classify (
        .data    (in_data),
        .is_zero (is_zero),
        .is_one  (is_one),
        .is_xz   (is_xz),
        .is_nl   (is_nl)
    );

    assign byte_fire = in_valid && in_ready;

`ifdef RESPONSE_PARSER_XZ_EN
    assign is_digit = is_zero || is_one || is_xz;
`else
    assign is_digit = is_zero || is_one;
`endif

    // Single FSM process; every output is registered. in_ready and out_valid
    // are complementary views of the HOLD state, updated on entry and exit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_vec   <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            shift_reg <= '0;
            count     <= '0;
`ifdef RESPONSE_PARSER_XZ_EN
            known_reg <= '0;
            out_known <= '1;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (byte_fire) begin
                        if (in_data == ASCII_GT) begin
                            state <= SPACE;
                        end else if (is_nl) begin
                            state <= IDLE;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_PREFIX;
                            state    <= SKIP;
                        end
                    end
                end

                SPACE: begin
                    if (byte_fire) begin
                        if (in_data == ASCII_SPACE) begin
                            state     <= DIGITS;
                            shift_reg <= '0;
                            count     <= '0;
`ifdef RESPONSE_PARSER_XZ_EN
                            known_reg <= '0;
`endif
                        end else begin
                            // A newline already ends the line, so there is
                            // nothing left to skip.
                            err      <= 1'b1;
                            err_code <= ERR_BAD_PREFIX;
                            state    <= is_nl ? IDLE : SKIP;
                        end
                    end
                end

                DIGITS: begin
                    if (byte_fire) begin
                        if (is_digit) begin
                            // The length check comes before the increment,
                            // so the counter never exceeds WIDTH.
                            if (count == FULL_COUNT) begin
                                err      <= 1'b1;
                                err_code <= ERR_LONG;
                                state    <= SKIP;
                            end else begin
                                shift_reg <= (shift_reg << 1) | WIDTH'(is_one);
`ifdef RESPONSE_PARSER_XZ_EN
                                known_reg <= (known_reg << 1) | WIDTH'(is_zero || is_one);
`endif
                                count     <= count + CNT_W'(1);
                            end
                        end else if (is_nl) begin
                            if (count == FULL_COUNT) begin
                                out_vec   <= shift_reg;
`ifdef RESPONSE_PARSER_XZ_EN
                                out_known <= known_reg;
`endif
                                out_valid <= 1'b1;
                                in_ready  <= 1'b0;
                                state     <= HOLD;
                            end else begin
                                err      <= 1'b1;
                                err_code <= ERR_SHORT;
                                state    <= IDLE;
                            end
                        end
`ifndef RESPONSE_PARSER_XZ_EN
                        else if (is_xz) begin
                            // Unknown/high-Z digits are not representable
                            // in this build.
                            err      <= 1'b1;
                            err_code <= ERR_BAD_DIGIT;
                            state    <= SKIP;
                        end
`endif
                        else begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_DIGIT;
                            state    <= SKIP;
                        end
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                SKIP: begin
                    if (byte_fire && is_nl) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/response_line_parser.md
Name: response_line_parser

Overview:
- Consumes the ASCII byte stream produced by the simulation-side bench: one line per step, of the form "> " + binary digits + "\n".
- Converts each well-formed line into a WIDTH-bit vector handed downstream on a valid/ready interface.
- Flags malformed lines.
- Sits between the byte-level stdout transport and the vector comparator in the hardware test runner; it is the reader for the bench's response writer.

Parameters:
- WIDTH, 5, number of binary digits per response line (4-bit OUT plus TC by default); legal range 1..32.

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- in_data  in  8  ASCII byte from transport
- in_valid  in  1  in_data valid
- in_ready  out  1  parser accepts in_data this cycle
- out_vec  out  WIDTH  parsed vector; first digit received = MSB
- out_valid  out  1  out_vec valid
- out_ready  in  1  downstream accepts out_vec
- err  out  1  one-cycle pulse on malformed line
- err_code  out  3  cause of the last error; held until the next error or reset

Behaviour:
- Byte transfer occurs when in_valid && in_ready. Vector transfer occurs when out_valid && out_ready.
- Reset values: in_ready=1, out_vec=0, out_valid=0, err=0, err_code=0, state=IDLE, digit count=0.
- FSM states:
  - IDLE
    - '>' -> SPACE.
    - '\n' -> stays IDLE; blank line ignored, no error.
    - Anything else -> err, code 1 (BAD_PREFIX), -> SKIP.
  - SPACE
    - ' ' -> DIGITS; clear shift register and count.
    - Anything else -> code 1, -> SKIP. A '\n' here -> code 1, -> IDLE.
  - DIGITS
    - '0'/'1' -> shift in at LSB, count+1.
    - If count is already WIDTH when a digit arrives -> code 4 (LONG), -> SKIP.
    - '\n' with count==WIDTH -> load out_vec, -> HOLD.
    - '\n' with count<WIDTH -> code 3 (SHORT), -> IDLE.
    - Any other byte -> code 2 (BAD_DIGIT), -> SKIP.
  - HOLD
    - out_valid=1, in_ready=0.
    - On out_ready -> IDLE; in_ready returns to 1 the next cycle.
  - SKIP
    - Discard bytes until '\n', then -> IDLE.
    - No further err pulses for the same line.
- Timing:
  - Throughput: one byte per cycle in every state except HOLD.
  - Latency: out_valid rises the cycle after the '\n' transfer.
  - out_vec is stable while out_valid=1.
- err asserts the cycle after the offending byte transfer, for exactly one cycle.
- The digit counter is $clog2(WIDTH+1) bits wide; it saturates conceptually at WIDTH and never wraps (the LONG check precedes the increment).
- Reset asserted mid-line discards the partial line. Reset during HOLD drops the pending vector (out_valid=0 on the next cycle).
- Simultaneous RESET and byte transfer: reset wins; the byte is lost.
- No other bytes ('\r' included) are tolerated inside a line.

Optional Feature:
- Macro: RESPONSE_PARSER_XZ_EN.
- Defined:
  - Adds port out_known (out, WIDTH).
  - Digits 'x','X','z','Z' are accepted in DIGITS. Each shifts 0 into out_vec and 0 into out_known; '0'/'1' shift 1 into out_known.
  - out_known follows the same timing and reset (all ones at reset) as out_vec.
- Undefined:
  - No out_known port.
  - x/z characters are BAD_DIGIT (code 2).

Decomposition:
- Package response_parser_pkg:
  - State enum {IDLE, SPACE, DIGITS, HOLD, SKIP}.
  - Error-code constants: NONE=0, BAD_PREFIX=1, BAD_DIGIT=2, SHORT=3, LONG=4.
  - ASCII constants: '>', ' ', '\n', '0', '1', 'x', 'z'.
- One natural sub-module: ascii_bin_classify, a combinational byte -> {is_zero, is_one, is_xz, is_nl} decoder.
- FSM, shift register and counter stay in the top module.

Test Plan:
- Well-formed line: WIDTH=5, bytes "> 10110\n" back-to-back, out_ready=1 -> out_valid one cycle after '\n', out_vec=5'b10110, err never set.
- Backpressure: two lines "> 00001\n> 11111\n", out_ready=0 for 10 cycles -> out_vec=5'b00001 held; in_ready=0 throughout HOLD; second line parsed after release, yielding 5'b11111.
- Short line: "> 101\n" -> err pulse on the '\n' cycle+1, err_code=3, no out_valid. Long line: "> 101101\n" -> err_code=4, no out_valid. Following "> 00000\n" parses correctly in both cases.
- Bad prefix/digit: "A 00000\n" -> err_code=1; "> 0020 0\n" -> err_code=2. Exactly one err pulse per line.
- Reset mid-line: "> 10" then RESET for 1 cycle, then "> 01010\n" -> only 5'b01010 emitted, err never set. Blank line "\n" -> ignored.
- XZ (macro defined): "> 1x0z1\n" -> out_vec=5'b10001, out_known=5'b10101. Macro undefined: the same line -> err_code=2.
